// File: rtl/dm_arbiter.sv
// Two-requester round-robin data-memory arbiter with word and byte access.
// Ports: clk, reset (async, active-low); per requester N in {0,1}:
//   mN_req/we/op/addr/wdata in, mN_gnt/ready/rdata out;
//   RAM side: ram_en, ram_we, ram_addr, ram_wdata out, ram_rdata in.
// Byte stores are read-modify-write: read the word, splice the lane, write.
module dm_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_op,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_op,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        MERGE,
        DONE
    } state_t;

    state_t state, state_nx;

    logic              rr;
    logic              win;
    logic              any_req;
    logic              both_req;
    logic              c_we;
    logic              c_id;
    logic [2:0]        c_op;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [31:0]       rword;
    logic [31:0]       merged;
    logic [31:0]       ld_data;
    logic [7:0]        ld_byte;
    logic [1:0]        lane;
    logic              is_word;
    logic              is_byte;
    logic              unused_addr;

    // Address bits above the RAM window are dropped, so accesses wrap.
    assign unused_addr = ^{m0_addr[31:ADDR_W], m1_addr[31:ADDR_W]};

    assign any_req  = m0_req | m1_req;
    assign both_req = m0_req & m1_req;
    // Under contention rr picks the winner; otherwise the lone requester wins.
    assign win      = both_req ? rr : m1_req;

    assign is_word  = (c_op == 3'b000);
    assign is_byte  = (c_op == 3'b001) || (c_op == 3'b101);
    assign lane     = c_addr[1:0];
    assign ram_addr = c_addr[ADDR_W-1:2];

    always_comb begin
        ld_byte = ram_rdata[{lane, 3'b000} +: 8];
        ld_data = '0;
        if (is_word) begin
            ld_data = ram_rdata;
        end else if (c_op == 3'b001) begin
            ld_data = {{24{ld_byte[7]}}, ld_byte};
        end else if (c_op == 3'b101) begin
            ld_data = {24'b0, ld_byte};
        end
    end

    always_comb begin
        merged = rword;
        merged[{lane, 3'b000} +: 8] = c_wdata[7:0];
    end

    always_comb begin
        state_nx  = state;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = c_wdata;
        unique case (state)
            IDLE: begin
                // Reset gating keeps gnt low while reset is held.
                if (any_req && reset) begin
                    m0_gnt   = ~win;
                    m1_gnt   = win;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                ram_en = 1'b1;
                if (c_we && is_word) begin
                    ram_we   = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                state_nx = (c_we && is_byte) ? MERGE : DONE;
            end
            MERGE: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = merged;
                state_nx  = DONE;
            end
            DONE: begin
                m0_ready = ~c_id;
                m1_ready = c_id;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr       <= 1'b0;
            c_we     <= 1'b0;
            c_id     <= 1'b0;
            c_op     <= '0;
            c_addr   <= '0;
            c_wdata  <= '0;
            rword    <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                c_id    <= win;
                c_we    <= win ? m1_we : m0_we;
                c_op    <= win ? m1_op : m0_op;
                c_addr  <= win ? m1_addr[ADDR_W-1:0] : m0_addr[ADDR_W-1:0];
                c_wdata <= win ? m1_wdata : m0_wdata;
                if (both_req) begin
                    rr <= ~win;
                end
            end
            if (state == WAIT) begin
                rword <= ram_rdata;
                // Everything that is not a byte store completes as a load.
                if (!(c_we && is_byte)) begin
                    if (c_id) begin
                        m1_rdata <= ld_data;
                    end else begin
                        m0_rdata <= ld_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_dm_arbiter;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 1 << (ADDR_W - 2);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [2:0]        m0_op = '0;
    logic [31:0]       m0_addr = '0, m0_wdata = '0;
    logic              m0_gnt, m0_ready;
    logic [31:0]       m0_rdata;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [2:0]        m1_op = '0;
    logic [31:0]       m1_addr = '0, m1_wdata = '0;
    logic              m1_gnt, m1_ready;
    logic [31:0]       m1_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = '0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] seed_word(input int i);
        logic [31:0] v;
        v = i;
        return (v * 32'h9E3779B1) ^ (v << 13) ^ 32'h5A5A0F0F;
    endfunction

    // Bench RAM
    logic [31:0]       mem [DEPTH];
    bit                init_done = 1'b0;
    logic              pl_en = 1'b0;
    logic [ADDR_W-3:0] pl_idx = '0;
    logic [31:0]       pl_val = '0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
            init_done <= 1'b1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    // Transaction-level reference model and per-cycle compare
    logic [31:0]       shadow [DEPTH];
    bit                sh_init = 1'b0;
    int                cyc = 0;
    bit                t_valid = 1'b0;
    int                t_own, t_g, t_lat, t_wc;
    logic [31:0]       t_wword, t_res;
    logic [ADDR_W-3:0] t_idx;
    bit                t_load;
    bit                m_rr = 1'b0;
    logic [31:0]       last_rd [2] = '{32'h0, 32'h0};
    bit                gseen [2] = '{1'b0, 1'b0};
    bit                eg0, eg1, er0, er1, een, ewe, free;
    int                win, ln;
    logic              x_we;
    logic [2:0]        x_op;
    logic [31:0]       x_a, x_w, x_word, x_b;

    always @(negedge clk) begin
        cyc++;
        if (!sh_init) begin
            for (int i = 0; i < DEPTH; i++) shadow[i] = seed_word(i);
            sh_init = 1'b1;
        end
        if (pl_en) shadow[pl_idx] = pl_val;
        gseen[0] = m0_gnt;
        gseen[1] = m1_gnt;
        if (!reset) begin
            chk("rst_outs", {m0_gnt, m1_gnt, m0_ready, m1_ready,
                             ram_en, ram_we}, 32'h0);
            chk("rst_rdata0", m0_rdata, 32'h0);
            chk("rst_rdata1", m1_rdata, 32'h0);
            t_valid = 1'b0;
            m_rr = 1'b0;
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            free = !t_valid || (cyc > t_g + t_lat);
            eg0 = 1'b0;
            eg1 = 1'b0;
            win = 0;
            if (free && (m0_req || m1_req)) begin
                win = (m0_req && m1_req) ? int'(m_rr) : (m1_req ? 1 : 0);
                eg0 = (win == 0);
                eg1 = (win == 1);
            end
            er0 = t_valid && cyc == t_g + t_lat && t_own == 0;
            er1 = t_valid && cyc == t_g + t_lat && t_own == 1;
            een = t_valid && (cyc == t_g + 1 || cyc == t_wc);
            ewe = t_valid && cyc == t_wc;
            chk("gnt", {m1_gnt, m0_gnt}, {eg1, eg0});
            chk("ready", {m1_ready, m0_ready}, {er1, er0});
            chk("ram_en", ram_en, een);
            chk("ram_we", ram_we, ewe);
            if (een) chk("ram_addr", ram_addr, t_idx);
            if (ewe) begin
                chk("ram_wdata", ram_wdata, t_wword);
                shadow[t_idx] = t_wword;
            end
            if ((er0 || er1) && t_load) last_rd[t_own] = t_res;
            chk("m0_rdata", m0_rdata, last_rd[0]);
            chk("m1_rdata", m1_rdata, last_rd[1]);
            if (eg0 || eg1) begin
                x_we = win ? m1_we : m0_we;
                x_op = win ? m1_op : m0_op;
                x_a  = win ? m1_addr : m0_addr;
                x_w  = win ? m1_wdata : m0_wdata;
                t_valid = 1'b1;
                t_own = win;
                t_g = cyc;
                t_idx = x_a[ADDR_W-1:2];
                ln = int'(x_a[1:0]);
                x_word = shadow[t_idx];
                t_wc = -1;
                t_load = 1'b1;
                t_res = '0;
                t_lat = 3;
                if (x_we && x_op == 3'b000) begin
                    t_lat = 2;
                    t_wc = cyc + 1;
                    t_wword = x_w;
                    t_load = 1'b0;
                end else if (x_we && (x_op == 3'b001 || x_op == 3'b101)) begin
                    t_lat = 4;
                    t_wc = cyc + 3;
                    t_wword = (x_word & ~(32'hFF << (8 * ln)))
                            | ({24'h0, x_w[7:0]} << (8 * ln));
                    t_load = 1'b0;
                end else if (!x_we && x_op == 3'b000) begin
                    t_res = x_word;
                end else if (!x_we && (x_op == 3'b001 || x_op == 3'b101)) begin
                    x_b = (x_word >> (8 * ln)) & 32'hFF;
                    if (x_op == 3'b001 && x_b[7]) x_b = x_b | 32'hFFFFFF00;
                    t_res = x_b;
                end
                if (m0_req && m1_req) m_rr = (win == 0);
            end
        end
    end

    task automatic drive(input int n, input logic r, input logic we,
                         input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] w);
        if (n == 0) begin
            m0_req = r; m0_we = we; m0_op = op; m0_addr = a; m0_wdata = w;
        end else begin
            m1_req = r; m1_we = we; m1_op = op; m1_addr = a; m1_wdata = w;
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pl_idx = idx[ADDR_W-3:0];
        pl_val = val;
        pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Waits for requester n's grant; returns aligned at the grant negedge.
    task automatic wait_gnt(input int n, output bit got);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (n == 0 ? m0_gnt : m1_gnt) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) chk("gnt_timeout", 32'h0, 32'h1);
    endtask

    task automatic xact(input int n, input logic we, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] w,
                        output int lat, output logic [31:0] rd);
        bit got;
        lat = -1;
        rd = '0;
        drive(n, 1'b1, we, op, a, w);
        wait_gnt(n, got);
        @(posedge clk); #1;
        drive(n, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        if (!got) return;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (n == 0 ? m0_ready : m1_ready) begin
                lat = k;
                rd = (n == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        if (lat < 0) chk("ready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic rnd_drv(input int n, input int ncyc);
        bit active = 1'b0;
        logic [2:0] ops [8] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd1, 3'd5, 3'd2, 3'd7};
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (active && gseen[n]) active = 1'b0;
            if (!active && $urandom_range(0, 2) != 0) begin
                active = 1'b1;
                drive(n, 1'b1, 1'($urandom_range(0, 1)),
                      ops[$urandom_range(0, 7)],
                      $urandom & 32'hFFFFF03F, $urandom);
            end else if (!active) begin
                drive(n, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            end
        end
        drive(n, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    task automatic rnd_rst(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 299) == 0) reset = 1'b0;
        end
        reset = 1'b1;
    endtask

    int          lat, nrdy, ng, both;
    logic [31:0] rd;
    logic [3:0]  ord;
    bit          got;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_gnt_blocked", m0_gnt, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;

        // Word store then load
        xact(0, 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, lat, rd);
        chk("wst_lat", lat, 2);
        chk("wst_mem", mem[4], 32'hDEADBEEF);
        xact(0, 1'b0, 3'b000, 32'h10, 32'h0, lat, rd);
        chk("wld_lat", lat, 3);
        chk("wld_data", rd, 32'hDEADBEEF);

        // Byte read-modify-write
        preload(4, 32'h11223344);
        xact(1, 1'b1, 3'b001, 32'h12, 32'h000000AA, lat, rd);
        chk("bst_lat", lat, 4);
        chk("bst_mem", mem[4], 32'h11AA3344);

        // Byte loads
        preload(4, 32'h80FF0001);
        xact(1, 1'b0, 3'b001, 32'h13, 32'h0, lat, rd);
        chk("bld_s_lat", lat, 3);
        chk("bld_s_data", rd, 32'hFFFFFF80);
        xact(0, 1'b0, 3'b101, 32'h13, 32'h0, lat, rd);
        chk("bld_u_data", rd, 32'h00000080);
        xact(1, 1'b0, 3'b001, 32'h10, 32'h0, lat, rd);
        chk("bld_l0_data", rd, 32'h00000001);

        // Address wrap and op 101 store
        xact(0, 1'b1, 3'b000, 32'hABC01010, 32'hCAFEF00D, lat, rd);
        chk("wrap_mem", mem[4], 32'hCAFEF00D);
        xact(1, 1'b1, 3'b101, 32'h11, 32'h00000077, lat, rd);
        chk("bst101_lat", lat, 4);
        chk("bst101_mem", mem[4], 32'hCAFE770D);

        // Illegal op store
        preload(6, 32'h12345678);
        xact(0, 1'b1, 3'b010, 32'h18, 32'hFFFFFFFF, lat, rd);
        chk("ill_lat", lat, 3);
        chk("ill_rdata", rd, 32'h0);
        chk("ill_mem", mem[6], 32'h12345678);

        // Contention from a fresh reset
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
        drive(1, 1'b1, 1'b0, 3'b000, 32'h44, 32'h0);
        ng = 0; both = 0; ord = '0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            @(negedge clk);
            if (m0_gnt && m1_gnt) both++;
            if (m0_gnt || m1_gnt) begin
                ord = {ord[2:0], m1_gnt};
                ng++;
            end
            if (ng < 4) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("rr_count", ng, 4);
        chk("rr_order", ord, 4'b0101);
        chk("rr_both", both, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset during MERGE
        preload(8, 32'h0);
        drive(0, 1'b1, 1'b1, 3'b001, 32'h20, 32'h55);
        wait_gnt(0, got);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("merge_we_pre", ram_we, 1'b1);
        reset = 1'b0;
        #1;
        chk("merge_we_rst", ram_we, 1'b0);
        nrdy = 0;
        repeat (2) begin @(negedge clk); nrdy += int'(m0_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (6) begin @(negedge clk); nrdy += int'(m0_ready); end
        chk("abort_ready", nrdy, 0);
        chk("abort_mem", mem[8], 32'h0);
        @(posedge clk); #1;

        // Randomized traffic with occasional resets
        fork
            rnd_drv(0, 3000);
            rnd_drv(1, 3000);
            rnd_rst(3000);
        join
        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address bits decoded; RAM depth is 2^(ADDR_W-2) words.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have, for N = 0 and 1, port mN_req  input  1  access request from requester N.
REQ-005 SHALL have port mN_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port mN_op  input  3  3'b000 = word, 3'b001 = signed byte, 3'b101 = unsigned byte.
REQ-007 SHALL have port mN_addr  input  32  byte address.
REQ-008 SHALL have port mN_wdata  input  32  store data; bits [7:0] are used for byte stores.
REQ-009 SHALL have port mN_gnt  output  1  one-cycle pulse when the request is captured.
REQ-010 SHALL have port mN_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port mN_rdata  output  32  load result, valid while mN_ready = 1.
REQ-012 SHALL have port ram_en  output  1  RAM access strobe.
REQ-013 SHALL have port ram_we  output  1  RAM write enable, qualified by ram_en.
REQ-014 SHALL have port ram_addr  output  ADDR_W-2  word address.
REQ-015 SHALL have port ram_wdata  output  32  RAM write word.
REQ-016 SHALL have port ram_rdata  input  32  RAM read word, valid the cycle after ram_en=1, ram_we=0.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, WAIT, MERGE and DONE.
REQ-018 IDLE: if any mN_req=1, SHALL pulse the winner's mN_gnt, capture its we/op/addr/wdata/id, and go to ACCESS; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: a single request wins outright; when both requests are active, the requester named by pointer rr wins, then rr becomes the other requester.
REQ-020 mN_req SHALL be ignored outside IDLE; a requester SHALL hold req and its fields until gnt.
REQ-021 ACCESS, word store: SHALL drive ram_en=1, ram_we=1, ram_wdata=wdata, then go to DONE.
REQ-022 ACCESS, load or byte store: SHALL drive ram_en=1, ram_we=0, then go to WAIT.
REQ-023 WAIT: SHALL register ram_rdata; a load then goes to DONE, a byte store goes to MERGE.
REQ-024 MERGE: SHALL write the registered word with byte lane addr[1:0] (0 = [7:0] ... 3 = [31:24]) replaced by wdata[7:0], then go to DONE.
REQ-025 DONE: SHALL pulse the owning mN_ready for one cycle, then go to IDLE; the other mN_ready SHALL stay 0.
REQ-026 Latency from the gnt cycle t SHALL be: ready at t+2 for a word store, t+3 for a load, t+4 for a byte store.
REQ-027 Word load SHALL return the full word; addr[1:0] SHALL be ignored for word ops.
REQ-028 Byte loads SHALL select the lane given by addr[1:0]; op 001 sign-extends bit 7 and op 101 zero-extends.
REQ-029 Stores SHALL treat op 101 as op 001.
REQ-030 Any other op SHALL cause no RAM write, return rdata 0, and complete as a load (t+3).
REQ-031 ram_addr SHALL equal addr[ADDR_W-1:2]; higher address bits SHALL be ignored, so addresses wrap.
REQ-032 mN_rdata SHALL hold its last value outside ready cycles.
REQ-033 ram_en and ram_we SHALL be 0 in IDLE, WAIT and DONE.
REQ-034 A request asserted in the DONE cycle SHALL be granted in the following IDLE cycle, giving a 1-cycle bubble minimum.

Reset
REQ-035 While reset=0, state SHALL go to IDLE asynchronously and rr to 0.
REQ-036 While reset=0, all gnt, ready, ram_en and ram_we outputs SHALL be 0, and rdata and captured registers SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL abort without any further RAM write; a byte store aborted before MERGE SHALL leave the RAM unchanged.
REQ-038 After reset is released, the first active clock edge in IDLE SHALL be able to grant.

Verification
REQ-039 Word store then load: m0 stores 0xDEADBEEF at addr 0x10, then loads it -> ram write at ram_addr 4, ready at t+2; load ready at t+3 with m0_rdata=0xDEADBEEF.
REQ-040 Byte RMW: RAM[4]=0x11223344; m1 stores byte wdata=0xAA at addr 0x12 -> ready at t+4, RAM[4]=0x11AA3344.
REQ-041 Byte loads: RAM[4]=0x80FF0001; op 001 at addr 0x13 -> 0xFFFFFF80; op 101 at addr 0x13 -> 0x00000080; op 001 at addr 0x10 -> 0x00000001.
REQ-042 Contention: m0_req and m1_req held high for 4 transactions -> grants alternate m0, m1, m0, m1; no cycle has both gnt=1.
REQ-043 Reset during MERGE of a byte store to addr 0x20 with RAM[8]=0x0 -> ram_we stays 0, RAM[8]=0x0, and no ready pulse occurs.
REQ-044 Illegal op 3'b010 store -> no ram_we pulse, ready at t+3, rdata=0.
